qdma_mailbox_fifo_reader: RTL and testbench
===========================================

Name: qdma_mailbox_fifo_reader

Overview:
Read-side engine for the mailbox generic FIFO. It drains FIFO words, which are presented combinationally at the FIFO read pointer and dequeued by a read-enable pulse, into a valid/ready message stream. It frames messages using a length field in each header word and decouples the FIFO from downstream backpressure through a 2-entry output skid buffer. It sits between the mailbox FIFO and the mailbox consumer (register-file or AXI4-MM response path).

Parameters:
DATAWIDTH, 256, FIFO and stream word width
LEN_W, 8, width of header length field at header bits [LEN_W-1:0]
MAX_MSG_WORDS, 16, largest legal message length in words, header included
CNT_W, 16, completed-message counter width

Ports:
clkin  in  1  clock
reset_n  in  1  asynchronous active-low reset
sync_reset_n  in  1  synchronous active-low flush, same meaning as on the FIFO
fifo_data  in  DATAWIDTH  FIFO DataOut, valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag, registered, deasserts one cycle after the count goes nonzero
fifo_rd_en  out  1  FIFO RdEn; one word dequeued per cycle when high
m_data  out  DATAWIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_sop  out  1  current beat is a header word
m_last  out  1  current beat is the last word of its message
msg_err  out  1  one-cycle pulse: illegal header length seen
msg_cnt  out  CNT_W  count of completed messages (m_last accepted); wraps

Behaviour:
- One clock, clkin. Reset is asynchronous, active-low, on reset_n.
- Reset values (reset_n=0): fifo_rd_en=0, m_valid=0, m_sop=0, m_last=0, msg_err=0, msg_cnt=0, m_data=0, FSM=HDR, word counter=0, skid buffer empty.
- fifo_rd_en is combinational: ~fifo_empty & sync_reset_n & (skid occupancy < 2 after this cycle's pop). It never asserts while fifo_empty=1.
- A word is captured into the skid buffer in the same cycle fifo_rd_en=1, using fifo_data from that cycle.
- Latency: fifo_empty falls at cycle N, so fifo_rd_en=1 at N and m_valid=1 at N+1.
- Sustained throughput is 1 word/cycle while m_ready=1 and the FIFO stays non-empty.
- Skid buffer: 2 entries holding {data, sop, last}, in-order. Head drives m_*. Pop when m_valid & m_ready. Simultaneous push and pop is allowed at any occupancy. Occupancy 2 with no pop forces fifo_rd_en=0.
- m_data, m_sop and m_last hold stable while m_valid=1 and m_ready=0.
- Framing FSM, advanced on each dequeue (fifo_rd_en=1):
  - HDR: word is tagged sop=1. L = data[LEN_W-1:0].
    - If L==0 or L>MAX_MSG_WORDS: msg_err pulses next cycle and L is treated as 1.
    - If the effective L==1: the word is tagged last=1 and the FSM stays in HDR.
    - Otherwise: remaining=L-1 and the FSM goes to BODY.
  - BODY: word is tagged sop=0. remaining decrements. When remaining==1, the word is tagged last=1 and the FSM goes to HDR.
- Remaining counter width is $clog2(MAX_MSG_WORDS+1). It never underflows.
- msg_cnt increments on each accepted beat with m_last=1, and wraps 2^CNT_W-1 to 0.
- sync_reset_n=0, registered effect at the next edge, even mid-message:
  - skid buffer emptied, m_valid=0, FSM=HDR, remaining=0, msg_err=0.
  - msg_cnt is kept.
  - fifo_rd_en is 0 that cycle, because the FIFO is flushing concurrently.
- The FIFO empty flag can lag by one cycle. The reader relies only on fifo_empty, and reads at most one word per cycle, so it never underflows.

Decomposition:
- Package qdma_mailbox_pkg:
  - typedef rd_state_e {HDR, BODY}
  - typedef skid entry struct {data, sop, last}
  - MAX_MSG_WORDS default constant
  - function hdr_len_legal()
- Sub-module qdma_mailbox_skid_buf: 2-entry valid/ready buffer, parameterized on payload width, reusable on the write side.

Test Plan:
- Single 1-word message, header L=1, m_ready=1: fifo_empty falls at cycle 0 -> fifo_rd_en=1 at 0; m_valid/m_sop/m_last=1 at cycle 1; msg_cnt=1 at cycle 2.
- Three back-to-back messages with L=4, 2, 3 preloaded, m_ready=1 -> 9 consecutive beats; sop on beats 1, 5, 7; last on beats 4, 6, 9; msg_cnt=3.
- Backpressure: 6 words queued, m_ready=0 for 10 cycles -> exactly 2 dequeues, then fifo_rd_en=0 and m_data stable; release m_ready -> remaining 4 words follow, in order, with no gap.
- Illegal headers L=0 and L=MAX_MSG_WORDS+1 -> msg_err pulses once per header; each is emitted as a single beat with sop=last=1; the next word is parsed as a header.
- sync_reset_n pulsed after word 2 of an L=5 message -> m_valid=0 next cycle, no further beats from that message; the next pushed word is treated as a header; msg_cnt unchanged.
- Asynchronous reset_n asserted mid-stream with m_valid=1 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qdma_mailbox_pkg.sv
// Shared types and helpers for the mailbox FIFO read/write engines.
package qdma_mailbox_pkg;

    localparam int unsigned MBX_DATAWIDTH     = 256;
    localparam int unsigned MBX_MAX_MSG_WORDS = 16;

    typedef logic [0:0] rd_state_e;
    localparam rd_state_e HDR  = 1'b0;
    localparam rd_state_e BODY = 1'b1;

    typedef struct packed {
        logic [MBX_DATAWIDTH-1:0] data;
        logic                     sop;
        logic                     last;
    } skid_entry_t;

    function automatic logic hdr_len_legal(input int unsigned len, input int unsigned max_words);
        return (len != 0) && (len <= max_words);
    endfunction

endpackage

// File: rtl/qdma_mailbox_skid_buf.sv
// Two-entry in-order valid/ready buffer; push and pop may coincide at any occupancy.
module qdma_mailbox_skid_buf #(
    parameter int unsigned WIDTH = 258
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign pop         = out_valid_o & out_ready_i;
    // Full is only a stall when the head is not leaving this cycle.
    assign in_ready_o  = (cnt_q != 2'd2) | pop;
    assign push        = in_valid_i & in_ready_o;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_d = in_data_i;
                    else               tail_d = in_data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = in_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/qdma_mailbox_fifo_reader.sv
// Drains mailbox FIFO words into a framed valid/ready message stream using header lengths.
module qdma_mailbox_fifo_reader
    import qdma_mailbox_pkg::*;
#(
    parameter int unsigned DATAWIDTH     = MBX_DATAWIDTH,
    parameter int unsigned LEN_W         = 8,
    parameter int unsigned MAX_MSG_WORDS = MBX_MAX_MSG_WORDS,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clkin,
    input  logic                 reset_n,
    input  logic                 sync_reset_n,
    input  logic [DATAWIDTH-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_sop,
    output logic                 m_last,
    output logic                 msg_err,
    output logic [CNT_W-1:0]     msg_cnt
);

    localparam int unsigned REM_W = $clog2(MAX_MSG_WORDS + 1);
    localparam int unsigned ENT_W = DATAWIDTH + 2;

    rd_state_e        state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             msg_err_q, msg_err_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;

    logic [LEN_W-1:0] hdr_len;
    logic             hdr_legal;
    logic             tag_sop, tag_last;
    logic             skid_in_ready, skid_out_valid;
    logic [ENT_W-1:0] skid_out_data;

    assign hdr_len   = fifo_data[LEN_W-1:0];
    assign hdr_legal = hdr_len_legal(32'(hdr_len), MAX_MSG_WORDS);

    // The FIFO flushes alongside us on sync_reset_n, so no dequeue that cycle.
    assign fifo_rd_en = ~fifo_empty & sync_reset_n & reset_n & skid_in_ready;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        msg_err_d = 1'b0;
        tag_sop   = 1'b0;
        tag_last  = 1'b0;
        if (!sync_reset_n) begin
            state_d = HDR;
            rem_d   = '0;
        end else if (fifo_rd_en) begin
            case (state_q)
                HDR: begin
                    tag_sop   = 1'b1;
                    msg_err_d = ~hdr_legal;
                    // Illegal lengths are framed as single-word messages.
                    if (!hdr_legal || hdr_len == LEN_W'(1)) begin
                        tag_last = 1'b1;
                    end else begin
                        rem_d   = REM_W'(hdr_len - LEN_W'(1));
                        state_d = BODY;
                    end
                end
                default: begin
                    if (rem_q <= REM_W'(1)) begin
                        tag_last = 1'b1;
                        rem_d    = '0;
                        state_d  = HDR;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        msg_cnt_d = msg_cnt_q;
        if (skid_out_valid && m_ready && skid_out_data[0]) begin
            msg_cnt_d = msg_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HDR;
            rem_q     <= '0;
            msg_err_q <= 1'b0;
            msg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            msg_err_q <= msg_err_d;
            msg_cnt_q <= msg_cnt_d;
        end
    end

    qdma_mailbox_skid_buf #(
        .WIDTH (ENT_W)
    ) u_skid (
        .clk_i       (clkin),
        .rst_ni      (reset_n),
        .flush_i     (~sync_reset_n),
        .in_valid_i  (fifo_rd_en),
        .in_ready_o  (skid_in_ready),
        .in_data_i   ({fifo_data, tag_sop, tag_last}),
        .out_valid_o (skid_out_valid),
        .out_ready_i (m_ready),
        .out_data_o  (skid_out_data)
    );

    assign m_valid = skid_out_valid;
    assign m_data  = skid_out_data[ENT_W-1:2];
    assign m_sop   = skid_out_data[1] & skid_out_valid;
    assign m_last  = skid_out_data[0] & skid_out_valid;
    assign msg_err = msg_err_q;
    assign msg_cnt = msg_cnt_q;

endmodule

// File: tb/tb_qdma_mailbox_fifo_reader.sv
// Directed and random stimulus for the mailbox FIFO reader against a message-level model.
module tb_qdma_mailbox_fifo_reader;

    localparam int unsigned DW   = 256;
    localparam int unsigned LW   = 8;
    localparam int unsigned MAXW = 16;
    localparam int unsigned CW   = 16;

    logic          clkin = 1'b0;
    logic          reset_n = 1'b0;
    logic          sync_reset_n = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_sop;
    logic          m_last;
    logic          msg_err;
    logic [CW-1:0] msg_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          last;
        int            cyc;
    } beat_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sent_q[$];
    beat_t         rx_q[$];
    beat_t         exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            pops = 0;
    int            err_pulses = 0;

    always #5 clkin = ~clkin;

    qdma_mailbox_fifo_reader #(
        .DATAWIDTH     (DW),
        .LEN_W         (LW),
        .MAX_MSG_WORDS (MAXW),
        .CNT_W         (CW)
    ) dut (
        .clkin        (clkin),
        .reset_n      (reset_n),
        .sync_reset_n (sync_reset_n),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sop        (m_sop),
        .m_last       (m_last),
        .msg_err      (msg_err),
        .msg_cnt      (msg_cnt)
    );

    // FIFO model: head visible when non-empty; empty flag registered, so pushes show a cycle late.
    always @(posedge clkin) begin
        logic [DW-1:0] dummy;
        cyc++;
        if (fifo_rd_en) begin
            dummy = fifo_q.pop_front();
            pops++;
        end
        if (!sync_reset_n) fifo_q.delete();
        fifo_empty <= (fifo_q.size() == 0);
        fifo_data  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    always @(negedge clkin) begin
        if (m_valid && m_ready) rx_q.push_back('{m_data, m_sop, m_last, cyc});
        if (msg_err) err_pulses++;
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    // Header word carries 'code' in its length field; illegal codes make a one-word message.
    task automatic send_msg(input int code);
        logic [DW-1:0] w;
        int            n;
        w = rnd_word();
        w[LW-1:0] = LW'(code);
        n = (code == 0 || code > int'(MAXW)) ? 1 : code;
        fifo_q.push_back(w);
        sent_q.push_back(w);
        for (int k = 1; k < n; k++) begin
            w = rnd_word();
            fifo_q.push_back(w);
            sent_q.push_back(w);
        end
    endtask

    // Expected beat stream from the raw word sequence: walk headers, emit L beats each.
    function automatic void model();
        int i;
        i = 0;
        exp_q.delete();
        while (i < sent_q.size()) begin
            logic [DW-1:0] w;
            int            len;
            w   = sent_q[i];
            len = int'(w[LW-1:0]);
            if (len == 0 || len > int'(MAXW)) len = 1;
            for (int k = 0; k < len; k++) begin
                exp_q.push_back('{sent_q[i+k], (k == 0), (k == len - 1), 0});
            end
            i += len;
        end
    endfunction

    task automatic drain_check(input string tag, input bit contiguous, input bit rnd_ready);
        int guard;
        guard = 0;
        model();
        while (rx_q.size() < exp_q.size() && guard < 4000) begin
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
        end
        m_ready = 1'b1;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), rx_q[i].data, exp_q[i].data);
            chk($sformatf("%s_sop%0d", tag, i), rx_q[i].sop, exp_q[i].sop);
            chk($sformatf("%s_last%0d", tag, i), rx_q[i].last, exp_q[i].last);
            if (contiguous) chk($sformatf("%s_gap%0d", tag, i), rx_q[i].cyc, rx_q[0].cyc + i);
        end
        rx_q.delete();
        sent_q.delete();
    endtask

    initial begin
        int exp_cnt;
        int p0;
        int e0;
        int n_ill;
        int code;
        exp_cnt = 0;

        // Reset values
        #2;
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_sop", m_sop, 1'b0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_err", msg_err, 1'b0);
        chk("rst_cnt", msg_cnt, '0);
        chk("rst_data", m_data, '0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single 1-word message: latency and count
        m_ready = 1'b1;
        send_msg(1);
        tick();
        chk("t1_rd_en_c0", fifo_rd_en, 1'b1);
        chk("t1_valid_c0", m_valid, 1'b0);
        tick();
        chk("t1_valid_c1", m_valid, 1'b1);
        chk("t1_sop_c1", m_sop, 1'b1);
        chk("t1_last_c1", m_last, 1'b1);
        chk("t1_data_c1", m_data, sent_q[0]);
        tick();
        exp_cnt++;
        chk("t1_cnt_c2", msg_cnt, CW'(exp_cnt));
        chk("t1_valid_c2", m_valid, 1'b0);
        rx_q.delete();
        sent_q.delete();

        // Back-to-back messages L=4,2,3
        send_msg(4);
        send_msg(2);
        send_msg(3);
        drain_check("b2b", 1'b1, 1'b0);
        tick();
        exp_cnt += 3;
        chk("b2b_cnt", msg_cnt, CW'(exp_cnt));

        // Backpressure: only two words leave the FIFO while stalled
        m_ready = 1'b0;
        p0 = pops;
        send_msg(6);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_data", m_data, sent_q[0]);
            chk("bp_hold_valid", m_valid, 1'b1);
        end
        chk("bp_pops", pops - p0, 2);
        chk("bp_rd_en", fifo_rd_en, 1'b0);
        drain_check("bp", 1'b1, 1'b0);
        exp_cnt += 1;
        tick();
        chk("bp_cnt", msg_cnt, CW'(exp_cnt));

        // Illegal header lengths at both ends
        e0 = err_pulses;
        send_msg(0);
        send_msg(MAXW + 1);
        send_msg(2);
        drain_check("ill", 1'b1, 1'b0);
        tick();
        exp_cnt += 3;
        chk("ill_err_pulses", err_pulses - e0, 2);
        chk("ill_cnt", msg_cnt, CW'(exp_cnt));

        // Synchronous flush mid-message
        m_ready = 1'b0;
        p0 = pops;
        send_msg(5);
        repeat (6) tick();
        chk("sr_pops", pops - p0, 2);
        sync_reset_n = 1'b0;
        #1;
        chk("sr_rd_en", fifo_rd_en, 1'b0);
        tick();
        sync_reset_n = 1'b1;
        chk("sr_valid", m_valid, 1'b0);
        m_ready = 1'b1;
        repeat (4) tick();
        chk("sr_no_beats", rx_q.size(), 0);
        chk("sr_cnt_kept", msg_cnt, CW'(exp_cnt));
        sent_q.delete();
        send_msg(1);
        drain_check("post_sr", 1'b0, 1'b0);
        tick();
        exp_cnt++;
        chk("post_sr_cnt", msg_cnt, CW'(exp_cnt));

        // Asynchronous reset mid-stream
        m_ready = 1'b0;
        send_msg(3);
        repeat (4) tick();
        chk("ar_pre_valid", m_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", m_valid, 1'b0);
        chk("ar_sop", m_sop, 1'b0);
        chk("ar_last", m_last, 1'b0);
        chk("ar_data", m_data, '0);
        chk("ar_cnt", msg_cnt, '0);
        chk("ar_rd_en", fifo_rd_en, 1'b0);
        fifo_q.delete();
        sent_q.delete();
        rx_q.delete();
        exp_cnt = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Random messages with random backpressure
        e0 = err_pulses;
        n_ill = 0;
        for (int m = 0; m < 30; m++) begin
            while ($urandom_range(0, 2) == 0) begin
                m_ready = 1'($urandom_range(0, 1));
                tick();
            end
            code = $urandom_range(0, MAXW + 2);
            if (code == 0 || code > int'(MAXW)) n_ill++;
            send_msg(code);
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain_check("rnd", 1'b0, 1'b1);
        tick();
        exp_cnt += 30;
        chk("rnd_err_pulses", err_pulses - e0, n_ill);
        chk("rnd_cnt", msg_cnt, CW'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
